param_control_unit: RTL and testbench

PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

---
 rtl/param_control_unit.sv | 116 +++++++++++
 tb/tb_param_control_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_control_unit.sv
// param_control_unit: multi-cycle fetch/decode/execute controller with Moore-decoded
// memory, register-file and program-counter strobes; illegal instructions halt until reset.
module param_control_unit #(
   parameter int DW        = 8,
   parameter int AW        = 16,
   parameter int NREG      = 8,
   parameter int WAIT_TIME = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DW-1:0]   data_bus_in,
   output logic [NREG-1:0] regs_rsel,
   output logic [NREG-1:0] regs_wsel,
   output logic            mem_ce,
   output logic            mem_oe,
   output logic            mem_r,
   output logic            mem_w,
   output logic            mem_rst,
   output logic            pc_inc,
   output logic            pc_r,
   output logic            pc_w,
   output logic            pc_rst,
   output logic [AW-1:0]   addr_bus_out,
   output logic            addr_bus_oe,
   output logic            halt
);
   localparam int ABYTES = AW / DW;
   localparam int BW     = ABYTES > 1 ? $clog2(ABYTES) : 1;
   localparam int WW     = WAIT_TIME > 0 ? $clog2(WAIT_TIME + 1) : 1;

   typedef enum logic [2:0] {WAIT, FETCH, EX0, ADDR, EXEC, HALT} state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [DW-1:0]   inst_q, inst_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [4:0]      op;
   logic [2:0]      r;
   logic [NREG-1:0] rsel;
   logic            is_ldi, is_str, is_ldr, is_jmp, legal, last, load, rd, ex;

   assign op     = inst_q[7:3];
   assign r      = inst_q[2:0];
   assign is_ldi = op == 5'b00000;
   assign is_str = op == 5'b10010;
   assign is_ldr = op == 5'b10001;
   assign is_jmp = op == 5'b11000;
   // JMP carries no register operand, so its r field is never range-checked
   assign legal  = is_jmp || ((is_ldi || is_str || is_ldr) && int'(r) < NREG);
   assign rsel   = NREG'(1) << r;
   assign last   = int'(bcnt_q) == ABYTES - 1;
   assign load   = (state_q == EX0 && legal && !is_ldi) || state_q == ADDR;
   assign rd     = state_q == FETCH || state_q == ADDR || (state_q == EX0 && legal);
   assign ex     = state_q == EXEC;

   assign mem_ce       = rd || (ex && !is_jmp);
   assign mem_oe       = rd || (ex && is_ldr);
   assign mem_r        = rd || (ex && is_ldr);
   assign mem_w        = ex && is_str;
   assign mem_rst      = state_q == WAIT;
   assign pc_inc       = rd;
   assign pc_r         = rd;
   assign pc_w         = ex && is_jmp;
   assign pc_rst       = state_q == WAIT;
   assign addr_bus_oe  = ex;
   assign addr_bus_out = addr_bus_oe ? addr_q : {AW{1'bz}};
   assign regs_wsel    = ((state_q == EX0 && legal && is_ldi) || (ex && is_ldr)) ? rsel : '0;
   assign regs_rsel    = (ex && is_str) ? rsel : '0;
   assign halt         = state_q == HALT;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      bcnt_d  = bcnt_q;
      inst_d  = inst_q;
      addr_d  = addr_q;
      case (state_q)
         WAIT: begin
            wcnt_d  = wcnt_q + WW'(1);
            state_d = wcnt_q == WW'(WAIT_TIME) ? FETCH : WAIT;
         end
         FETCH: begin
            inst_d  = data_bus_in;
            bcnt_d  = '0;
            state_d = EX0;
         end
         EX0:     state_d = !legal ? HALT : is_ldi ? FETCH : ABYTES == 1 ? EXEC : ADDR;
         ADDR:    state_d = last ? EXEC : ADDR;
         EXEC:    state_d = FETCH;
         default: state_d = HALT;
      endcase
      // address bytes arrive most-significant first
      if (load) begin
         bcnt_d = bcnt_q + BW'(1);
         for (int i = 0; i < ABYTES; i++)
            if (ABYTES - 1 - i == int'(bcnt_q)) addr_d[i*DW +: DW] = data_bus_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= WAIT;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         inst_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         inst_q  <= inst_d;
         addr_q  <= addr_d;
      end
   end
endmodule

// File: tb/tb_param_control_unit.sv
// tb_param_control_unit: directed instruction table, reset corner cases, a reduced build
// (AW=8, NREG=4) and a random program checked against an instruction-level interpreter.
module tb_param_control_unit;
   localparam logic [10:0] RD     = 11'b111_0_0_1_1_0_0_0_0;
   localparam logic [10:0] STR_EX = 11'b100_1_0_0_0_0_0_1_0;
   localparam logic [10:0] LDR_EX = 11'b111_0_0_0_0_0_0_1_0;
   localparam logic [10:0] JMP_EX = 11'b000_0_0_0_0_1_0_1_0;
   localparam logic [10:0] WAIT_C = 11'b000_0_1_0_0_0_1_0_0;
   localparam logic [10:0] HALT_C = 11'b000_0_0_0_0_0_0_0_1;

   logic clk = 0, rst_n = 0;
   logic [7:0] data_bus_in, d2 = 0;
   wire  [7:0] regs_rsel, regs_wsel;
   wire  [3:0] rsel2, wsel2;
   wire  [15:0] addr_bus_out;
   wire  [7:0] addr2;
   wire mem_ce, mem_oe, mem_r, mem_w, mem_rst, pc_inc, pc_r, pc_w, pc_rst, addr_bus_oe, halt;
   wire ce2, oe2, r2, w2, mrst2, inc2, pr2, pw2, prst2, aoe2, halt2;
   wire [10:0] ctl  = {mem_ce, mem_oe, mem_r, mem_w, mem_rst, pc_inc, pc_r, pc_w, pc_rst, addr_bus_oe, halt};
   wire [10:0] ctl2 = {ce2, oe2, r2, w2, mrst2, inc2, pr2, pw2, prst2, aoe2, halt2};

   logic [7:0]  mem [0:65535];
   logic [7:0]  mm  [0:65535];
   logic [7:0]  regf [0:7];
   logic [7:0]  rm   [0:7];
   logic [15:0] pc = 0;
   int total = 0, pass = 0, viol = 0, nw = 0;

   always #5 clk = ~clk;

   always_comb data_bus_in = mem_r ? mem[pc_r ? pc : addr_bus_out] : 8'h00;

   param_control_unit dut (
      .clk(clk), .rst_n(rst_n), .data_bus_in(data_bus_in),
      .regs_rsel(regs_rsel), .regs_wsel(regs_wsel),
      .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_r(mem_r), .mem_w(mem_w), .mem_rst(mem_rst),
      .pc_inc(pc_inc), .pc_r(pc_r), .pc_w(pc_w), .pc_rst(pc_rst),
      .addr_bus_out(addr_bus_out), .addr_bus_oe(addr_bus_oe), .halt(halt));

   param_control_unit #(.AW(8), .NREG(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .data_bus_in(d2),
      .regs_rsel(rsel2), .regs_wsel(wsel2),
      .mem_ce(ce2), .mem_oe(oe2), .mem_r(r2), .mem_w(w2), .mem_rst(mrst2),
      .pc_inc(inc2), .pc_r(pr2), .pc_w(pw2), .pc_rst(prst2),
      .addr_bus_out(addr2), .addr_bus_oe(aoe2), .halt(halt2));

   typedef struct {
      logic [15:0] at;
      int          nb;
      logic [23:0] bytes;
      int          lat;
      logic [10:0] ctl;
      logic [7:0]  wsel, rsel;
      logic [15:0] addr;
      bit          ca;
      string       nm;
   } vec_t;
   vec_t tv [7];

   function automatic int idx(logic [7:0] s);
      for (int i = 0; i < 8; i++) if (s[i]) return i;
      return 0;
   endfunction

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      total++;
      if (a === e) pass++;
      else $display("FAIL %s actual=%h required=%h", n, a, e);
   endtask

   // peer models: PC, memory and register file react to the strobes seen in the current cycle
   task automatic tick();
      logic [10:0] c;
      logic [7:0]  ws, rs, d;
      logic [15:0] a;
      if (!$onehot0(regs_wsel) || !$onehot0(regs_rsel) || (regs_wsel != 0 && regs_rsel != 0) ||
          (pc_w && pc_inc) || (mem_w && mem_oe)) viol++;
      if (mem_w) nw++;
      c = ctl; ws = regs_wsel; rs = regs_rsel; d = data_bus_in; a = addr_bus_out;
      @(posedge clk);
      #1;
      if (c[2]) pc = 0;
      else if (c[3]) pc = a;
      else if (c[5]) pc = pc + 1;
      if (c[7]) mem[a] = regf[idx(rs)];
      if (ws != 0) regf[idx(ws)] = d;
      @(negedge clk);
   endtask

   task automatic powerup();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   initial begin
      int k, t, p, exp_k;
      logic [15:0] a;
      logic [7:0]  b;
      tv[0] = '{16'h0000, 2, 24'h035A00, 2, RD,     8'h08, 8'h00, 16'h0000, 1'b0, "ldi_r3"};
      tv[1] = '{16'h0002, 3, 24'h921234, 4, STR_EX, 8'h00, 8'h04, 16'h1234, 1'b1, "str_r2"};
      tv[2] = '{16'h0005, 3, 24'h891234, 4, LDR_EX, 8'h02, 8'h00, 16'h1234, 1'b1, "ldr_r1"};
      tv[3] = '{16'h0008, 2, 24'h057700, 2, RD,     8'h20, 8'h00, 16'h0000, 1'b0, "ldi_r5"};
      tv[4] = '{16'h000A, 3, 24'hC0ABCD, 4, JMP_EX, 8'h00, 8'h00, 16'hABCD, 1'b1, "jmp"};
      tv[5] = '{16'hABCD, 3, 24'h941235, 4, STR_EX, 8'h00, 8'h10, 16'h1235, 1'b1, "str_r4"};
      tv[6] = '{16'hABD0, 1, 24'hF80000, 2, 11'h0,  8'h00, 8'h00, 16'h0000, 1'b0, "illegal"};
      for (int i = 0; i < 65536; i++) mem[i] = 8'hF8;
      for (int i = 0; i < 8; i++) regf[i] = 8'h10 + 8'(i);
      foreach (tv[i])
         for (int j = 0; j < tv[i].nb; j++) mem[tv[i].at + 16'(j)] = tv[i].bytes[23-8*j -: 8];
      @(negedge clk);
      powerup();
      for (int i = 0; i < 6; i++) begin
         chk("wait", {21'b0, ctl}, {21'b0, WAIT_C});
         tick();
      end
      foreach (tv[i]) begin
         chk({tv[i].nm, "_fetch"}, {21'b0, ctl}, {21'b0, RD});
         tick();
         for (int j = 1; j < tv[i].lat - 1; j++) begin
            chk({tv[i].nm, "_addr"}, {21'b0, ctl}, {21'b0, RD});
            tick();
         end
         chk({tv[i].nm, "_ctl"}, {21'b0, ctl}, {21'b0, tv[i].ctl});
         chk({tv[i].nm, "_wsel"}, {24'b0, regs_wsel}, {24'b0, tv[i].wsel});
         chk({tv[i].nm, "_rsel"}, {24'b0, regs_rsel}, {24'b0, tv[i].rsel});
         if (tv[i].ca) chk({tv[i].nm, "_addrbus"}, {16'b0, addr_bus_out}, {16'b0, tv[i].addr});
         tick();
      end
      chk("halt", {21'b0, ctl}, {21'b0, HALT_C});
      tick();
      tick();
      chk("halt_sticky", {21'b0, ctl}, {21'b0, HALT_C});
      chk("reg3", {24'b0, regf[3]}, 32'h5A);
      chk("reg5", {24'b0, regf[5]}, 32'h77);
      chk("reg1", {24'b0, regf[1]}, 32'h12);
      chk("mem1234", {24'b0, mem[16'h1234]}, 32'h12);
      chk("mem1235", {24'b0, mem[16'h1235]}, 32'h14);

      rst_n = 0;
      tick();
      rst_n = 1;
      chk("rst_from_halt", {21'b0, ctl}, {21'b0, WAIT_C});

      mem[0] = 8'h92; mem[1] = 8'h12; mem[2] = 8'h34;
      for (int i = 0; i < 8; i++) tick();
      chk("abort_in_addr", {21'b0, ctl}, {21'b0, RD});
      nw = 0;
      rst_n = 0;
      tick();
      chk("abort_wait", {21'b0, ctl}, {21'b0, WAIT_C});
      chk("abort_no_memw", nw, 0);

      tick();
      rst_n = 1;
      for (int i = 0; i < 6; i++) tick();
      d2 = 8'h89;
      chk("aw8_fetch", {21'b0, ctl2}, {21'b0, RD});
      tick();
      d2 = 8'h55;
      chk("aw8_ex0", {21'b0, ctl2}, {21'b0, RD});
      tick();
      chk("aw8_exec", {21'b0, ctl2}, {21'b0, LDR_EX});
      chk("aw8_addr", {24'b0, addr2}, 32'h55);
      chk("aw8_wsel", {28'b0, wsel2}, 32'h2);
      tick();
      d2 = 8'h06;
      tick();
      chk("nreg4_ex0", {17'b0, wsel2, ctl2}, 32'h0);
      tick();
      chk("nreg4_halt", {21'b0, ctl2}, {21'b0, HALT_C});

      rst_n = 0;
      tick();
      for (int i = 0; i < 65536; i++) mem[i] = 8'hF8;
      for (int i = 0; i < 16; i++) mem[16'h8000 + 16'(i)] = 8'($urandom);
      for (int i = 0; i < 8; i++) regf[i] = 8'($urandom);
      p = 0;
      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 3);
         b = 8'($urandom_range(0, 7));
         a = 16'h8000 + 16'($urandom_range(0, 15));
         if (k == 0) begin
            mem[p] = b; mem[p+1] = 8'($urandom); p += 2;
         end else if (k == 3) begin
            a = 16'(p + 3 + $urandom_range(0, 3));
            mem[p] = 8'hC0 | b; mem[p+1] = a[15:8]; mem[p+2] = a[7:0]; p = int'(a);
         end else begin
            mem[p] = (k == 1 ? 8'h90 : 8'h88) | b; mem[p+1] = a[15:8]; mem[p+2] = a[7:0]; p += 3;
         end
      end
      for (int i = 0; i < 65536; i++) mm[i] = mem[i];
      for (int i = 0; i < 8; i++) rm[i] = regf[i];
      a = 0;
      t = 0;
      for (int n = 0; n < 1000; n++) begin
         b = mm[a];
         p = int'({mm[a+16'd1], mm[a+16'd2]});
         if (b[7:3] == 5'b00000) begin rm[b[2:0]] = mm[a+16'd1]; a += 2; t += 2; end
         else if (b[7:3] == 5'b10010) begin mm[p] = rm[b[2:0]]; a += 3; t += 4; end
         else if (b[7:3] == 5'b10001) begin rm[b[2:0]] = mm[p]; a += 3; t += 4; end
         else if (b[7:3] == 5'b11000) begin a = 16'(p); t += 4; end
         else break;
      end
      tick();
      rst_n = 1;
      viol = 0;
      exp_k = 6 + t + 2;
      k = 0;
      while (!halt && k < 3000) begin
         tick();
         k++;
      end
      chk("rand_cycles_to_halt", k, exp_k);
      for (int i = 0; i < 8; i++) chk("rand_reg", {24'b0, regf[i]}, {24'b0, rm[i]});
      for (int i = 0; i < 16; i++)
         chk("rand_mem", {24'b0, mem[16'h8000 + 16'(i)]}, {24'b0, mm[16'h8000 + 16'(i)]});
      chk("rand_invariants", viol, 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
